// File: rtl/fifo_pop_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_pop_arbiter
//
// Drains eight FIFOs into one output stage. One FIFO is popped per cycle.
// The choice is round-robin among the non-empty FIFOs. Pops happen only while
// the flow-control FSM is ACTIVE and the downstream stage has no backpressure.
// The block also registers per-FIFO almost-full and almost-empty flags, which
// it derives from the FSM's latched thresholds.
//
// Build option:
//   FIFO_POP_ARB_STRICT_PRIO_EN - when defined, fixed priority (FIFO 0 highest);
//                                 the round-robin pointer is held at 0.
//
// Ports:
//   clk                 clock, rising edge
//   reset               asynchronous, active-low reset
//   fsm_state   [2:0]   FSM state (RESET=0, INIT=1, IDLE=2, ACTIVE=4)
//   umbral_LH           thresholds: [3:0] low, [7:4] high
//   empty_fifos [7:0]   bit i = FIFO i empty
//   fifo_cnt            FIFO i occupancy at [i*CNT_W +: CNT_W]
//   out_almost_full     downstream backpressure, blocks new pops
//   pop         [7:0]   one-hot registered read strobe
//   valid_out           read data valid, one cycle after pop
//   sel         [2:0]   index of the FIFO whose data is valid
//   almost_full_fifos   bit i = cnt_i >= high, registered
//   almost_empty_fifos  bit i = cnt_i <= low, registered
//   pause               OR of almost_full_fifos, registered
// -----------------------------------------------------------------------------
module fifo_pop_arbiter #(
    parameter int UMBRALES_L_H = 8,
    parameter int CNT_W        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              fsm_state,
    input  logic [UMBRALES_L_H-1:0] umbral_LH,
    input  logic [7:0]              empty_fifos,
    input  logic [8*CNT_W-1:0]      fifo_cnt,
    input  logic                    out_almost_full,
    output logic [7:0]              pop,
    output logic                    valid_out,
    output logic [2:0]              sel,
    output logic [7:0]              almost_full_fifos,
    output logic [7:0]              almost_empty_fifos,
    output logic                    pause
);

    localparam logic [2:0] ST_ACTIVE = 3'd4;

    // One-hot to index encoder; a zero vector maps to index 0.
    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       pop_q, pop_d;
    logic             valid_q;
    logic [2:0]       sel_q;
    logic [7:0]       af_q, af_d;
    logic [7:0]       ae_q, ae_d;
    logic             pause_q;

    logic             arb_en_s;
    logic [7:0]       cand_s;
    logic             grant_vld_s;
    logic [2:0]       grant_idx_s;
    logic [2:0]       idx_s;
    logic             hit_s;
    logic [CNT_W-1:0] high_s;
    logic [CNT_W-1:0] low_s;
    logic [CNT_W-1:0] cnt_s;

    // Arbitration: scan upward from the pointer (wrapping) for the first non-empty FIFO.
    always_comb begin
        arb_en_s    = (fsm_state == ST_ACTIVE) && !out_almost_full;
        cand_s      = ~empty_fifos;
        grant_vld_s = 1'b0;
        grant_idx_s = 3'd0;
        idx_s       = 3'd0;
        hit_s       = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx_s       = ptr_q + 3'(k);
            hit_s       = !grant_vld_s && cand_s[idx_s];
            grant_idx_s = hit_s ? idx_s : grant_idx_s;
            grant_vld_s = grant_vld_s | cand_s[idx_s];
        end

        pop_d = 8'h00;
        ptr_d = ptr_q;
        if (arb_en_s && grant_vld_s) begin
            pop_d = 8'd1 << grant_idx_s;
`ifdef FIFO_POP_ARB_STRICT_PRIO_EN
            ptr_d = 3'd0;
`else
            ptr_d = grant_idx_s + 3'd1;
`endif
        end else begin
            pop_d = 8'h00;
            ptr_d = ptr_q;
        end
    end

    // Threshold flags: unsigned compare against the 4-bit thresholds widened to CNT_W.
    always_comb begin
        high_s = CNT_W'(umbral_LH[7:4]);
        low_s  = CNT_W'(umbral_LH[3:0]);
        af_d   = 8'h00;
        ae_d   = 8'h00;
        cnt_s  = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_s   = fifo_cnt[i*CNT_W +: CNT_W];
            af_d[i] = (cnt_s >= high_s);
            ae_d[i] = (cnt_s <= low_s);
        end
    end

    // State and output registers; valid/sel are the pop strobe delayed one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= 3'd0;
            pop_q   <= 8'h00;
            valid_q <= 1'b0;
            sel_q   <= 3'd0;
            af_q    <= 8'h00;
            ae_q    <= 8'h00;
            pause_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            pop_q   <= pop_d;
            valid_q <= |pop_q;
            sel_q   <= onehot_idx(pop_q);
            af_q    <= af_d;
            ae_q    <= ae_d;
            pause_q <= |af_d;
        end
    end

    assign pop                = pop_q;
    assign valid_out          = valid_q;
    assign sel                = sel_q;
    assign almost_full_fifos  = af_q;
    assign almost_empty_fifos = ae_q;
    assign pause              = pause_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
module tb_fifo_pop_arbiter;

    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [2:0]         fsm_state;
    logic [7:0]         umbral_LH;
    logic [7:0]         empty_fifos;
    logic [8*CNT_W-1:0] fifo_cnt;
    logic               out_almost_full;
    logic [7:0]         pop;
    logic               valid_out;
    logic [2:0]         sel;
    logic [7:0]         almost_full_fifos;
    logic [7:0]         almost_empty_fifos;
    logic               pause;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state (plain integers)
    int m_ptr;
    int m_pop_idx;    // -1 = no pop
    int m_valid;
    int m_sel;
    int m_af;
    int m_ae;
    int m_pause;

    fifo_pop_arbiter #(.UMBRALES_L_H(8), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .fsm_state          (fsm_state),
        .umbral_LH          (umbral_LH),
        .empty_fifos        (empty_fifos),
        .fifo_cnt           (fifo_cnt),
        .out_almost_full    (out_almost_full),
        .pop                (pop),
        .valid_out          (valid_out),
        .sel                (sel),
        .almost_full_fifos  (almost_full_fifos),
        .almost_empty_fifos (almost_empty_fifos),
        .pause              (pause)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_pop_idx = -1; m_valid = 0; m_sel = 0;
        m_af = 0; m_ae = 0; m_pause = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        int g;
        int hi;
        int lo;
        int c;
        if (reset == 1'b0) begin
            model_reset();
        end else begin
            m_valid = (m_pop_idx >= 0) ? 1 : 0;
            m_sel   = (m_pop_idx >= 0) ? m_pop_idx : 0;
            g = -1;
            if (fsm_state == 3'd4 && out_almost_full == 1'b0) begin
                for (int k = 0; k < 8; k++) begin
                    if (g < 0 && empty_fifos[(m_ptr + k) % 8] == 1'b0) g = (m_ptr + k) % 8;
                end
            end
            m_pop_idx = g;
`ifdef FIFO_POP_ARB_STRICT_PRIO_EN
            m_ptr = 0;
`else
            if (g >= 0) m_ptr = (g + 1) % 8;
`endif
            hi = umbral_LH[7:4];
            lo = umbral_LH[3:0];
            m_af = 0; m_ae = 0;
            for (int i = 0; i < 8; i++) begin
                c = fifo_cnt[i*CNT_W +: CNT_W];
                if (c >= hi) m_af = m_af | (1 << i);
                if (c <= lo) m_ae = m_ae | (1 << i);
            end
            m_pause = (m_af != 0) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        check_val("pop", 32'(pop), (m_pop_idx >= 0) ? (32'd1 << m_pop_idx) : 32'd0);
        check_val("valid_out", 32'(valid_out), 32'(m_valid));
        if (m_valid != 0) check_val("sel", 32'(sel), 32'(m_sel));
        check_val("almost_full", 32'(almost_full_fifos), 32'(m_af));
        check_val("almost_empty", 32'(almost_empty_fifos), 32'(m_ae));
        check_val("pause", 32'(pause), 32'(m_pause));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [2:0] st_tab [5];
        st_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd4};
        model_reset();
        reset = 1'b0; fsm_state = 3'd0; umbral_LH = 8'h00; empty_fifos = 8'hFF;
        fifo_cnt = '0; out_almost_full = 1'b0;

        // Reset: everything 0
        repeat (3) cycle();
        check_val("rst_sel", 32'(sel), 32'd0);
        reset = 1'b1;

        // ACTIVE, all empty: no pops for 20 cycles
        fsm_state = 3'd4; umbral_LH = 8'hF0;
        repeat (20) cycle();

        // All non-empty: full rotation plus wrap
        empty_fifos = 8'h00;
        repeat (10) cycle();

        // Re-align pointer to 3, then candidates 3 and 5
        reset = 1'b0; @(negedge clk); model_reset(); reset = 1'b1;
        repeat (3) cycle();
        empty_fifos = 8'b1101_0111;
        repeat (5) cycle();

        // Backpressure mid-stream for 3 cycles
        empty_fifos = 8'h00;
        repeat (3) cycle();
        out_almost_full = 1'b1;
        repeat (3) cycle();
        out_almost_full = 1'b0;
        repeat (4) cycle();

        // Leave ACTIVE mid-stream
        fsm_state = 3'd2;
        repeat (3) cycle();
        fsm_state = 3'd4;
        repeat (2) cycle();

        // Threshold flags
        fsm_state = 3'd2; umbral_LH = 8'h92;
        for (int i = 0; i < 8; i++) fifo_cnt[i*CNT_W +: CNT_W] = 4'd5;
        fifo_cnt[0 +: CNT_W] = 4'd9;
        fifo_cnt[CNT_W +: CNT_W] = 4'd2;
        cycle();
        check_val("thr_af", 32'(almost_full_fifos), 32'h01);
        check_val("thr_ae", 32'(almost_empty_fifos), 32'h02);
        check_val("thr_pause", 32'(pause), 32'd1);
        umbral_LH = 8'h05;   // high == 0 -> all almost-full
        cycle();
        check_val("hi0_af", 32'(almost_full_fifos), 32'hFF);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            fsm_state       = st_tab[$urandom_range(0, 4)];
            empty_fifos     = 8'($urandom);
            out_almost_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) umbral_LH = 8'($urandom);
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 3) == 0) fifo_cnt[i*CNT_W +: CNT_W] = 4'($urandom);
            cycle();
        end

        // Reset in the cycle after a pop
        fsm_state = 3'd4; empty_fifos = 8'h00; out_almost_full = 1'b0;
        cycle();
        reset = 1'b0;
        #1;
        model_reset();
        check_val("arst_pop", 32'(pop), 32'd0);
        check_val("arst_valid", 32'(valid_out), 32'd0);
        check_val("arst_af", 32'(almost_full_fifos), 32'd0);
        check_val("arst_pause", 32'(pause), 32'd0);
        @(negedge clk);
        cycle();
        reset = 1'b1;
        cycle();
        check_val("restart_pop", 32'(pop), 32'h01);
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Downstream companion of the flow-control FSM: consumes its state, its latched low/high thresholds and the eight FIFO empty flags, and drains the eight FIFOs into a single output stage. Round-robin arbitration, one pop per cycle, gated by downstream backpressure. Per-FIFO almost-full/almost-empty flags are also generated from the FSM thresholds.

## Interface
- UMBRALES_L_H, 8, threshold bus width; [3:0] = low threshold, [7:4] = high threshold
- CNT_W, 4, width of each FIFO occupancy count
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- fsm_state  in  3  FSM state encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=4
- umbral_LH  in  UMBRALES_L_H  latched thresholds from the FSM
- empty_fifos  in  8  bit i = FIFO i empty
- fifo_cnt  in  8*CNT_W  FIFO i occupancy at bits [i*CNT_W +: CNT_W]
- out_almost_full  in  1  downstream backpressure; 1 blocks new pops
- pop  out  8  one-hot read strobe to FIFO i, registered
- valid_out  out  1  FIFO read data valid, one cycle after pop
- sel  out  3  index of the FIFO whose data is valid, qualified by valid_out
- almost_full_fifos  out  8  bit i = fifo_cnt_i >= high threshold, registered
- almost_empty_fifos  out  8  bit i = fifo_cnt_i <= low threshold, registered
- pause  out  1  OR of almost_full_fifos, registered alongside them

## Operation
- All outputs reset to 0. The round-robin pointer resets to 0.
- Arbitration is enabled only when fsm_state == 4 (ACTIVE) and out_almost_full == 0.
- Candidate set = ~empty_fifos. The grant goes to the first candidate at or after the pointer, searching upward and wrapping 7 -> 0.
- On a grant to FIFO g:
  - pop[g] = 1 for exactly one cycle.
  - The pointer becomes (g+1) mod 8.
- With no grant, pop = 0 and the pointer holds.
- At most one pop bit is set in any cycle.
- valid_out/sel are the pop pipeline delayed one cycle: valid_out = |pop of the previous cycle, and sel = its index.
- Threshold flags are evaluated every cycle, independent of fsm_state. Comparisons are unsigned; each count is compared against the 4-bit thresholds zero-extended to CNT_W.
- If low >= high, both flags may be set at once; this is legal and has no special handling.
- If high == 0, every almost_full bit is 1 and pause = 1.

## Timing
- Pop latency: the cycle fsm_state, empty_fifos and out_almost_full are sampled -> pop high at the next rising edge.
- Data latency: valid_out is one further cycle after pop, matching the one-cycle FIFO read latency.
- out_almost_full rising: pops stop from the next edge. A pop already issued still produces its valid_out.
- fsm_state leaving ACTIVE: same rule as backpressure. No new pops; in-flight valid_out completes; the pointer is kept.
- FIFO emptying while granted: empty_fifos is sampled in the grant cycle, so no pop is issued to a FIFO flagged empty in that cycle.
- Back-to-back grants to the same FIFO occur only when it is the sole candidate.
- Flag latency: one cycle from a fifo_cnt or umbral_LH change to the flag outputs.
- reset asserted mid-operation: pop, valid_out, sel, all flags, pause and the pointer clear asynchronously. An in-flight valid_out is dropped.

## Configuration
- FIFO_POP_ARB_STRICT_PRIO_EN
  - Defined: fixed priority, FIFO 0 highest. The grant is the lowest-index candidate, and the pointer is unused (held at 0).
  - Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then ACTIVE with empty_fifos=8'hFF -> pop=0 and valid_out=0 for 20 cycles; all outputs 0 during reset.
- ACTIVE, empty_fifos=8'h00, out_almost_full=0 -> pop sequence 01,02,04,...,80,01 on consecutive cycles, with valid_out=1 and sel=0..7 each lagging one cycle. Strict build: pop=01 every cycle.
- Pointer at 3, empty_fifos=8'b1101_0111 (candidates 3 and 5) -> grants 3, 5, 3, 5; sel follows one cycle later.
- Raise out_almost_full for 3 cycles mid-stream -> no pop for those 3 cycles, the last pre-stall valid_out still appears, and arbitration resumes at the saved pointer.
- umbral_LH=8'h92 (high=9, low=2); FIFO 0 cnt=9, FIFO 1 cnt=2, FIFO 2 cnt=5 -> almost_full_fifos=8'h01, almost_empty_fifos[1]=1 and [2]=0, pause=1 one cycle later.
- Assert reset in the cycle after a pop -> valid_out stays 0, pop and the flags clear immediately, and round-robin restarts at FIFO 0 after release.
